muldiv_unit: RTL and testbench

Iterative 32×32 multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. Sits in the execute stage directly downstream of the register file: consumes the two read-port operands (rd1 → `a`, rd2 → `b`) and holds products, quotients and remainders until MFHI/MFLO read them. It raises `busy` so the hazard logic stalls dependent instructions while an operation is in flight.

---
 rtl/mips_pkg.sv | 10 +
 rtl/muldiv_unit.sv | 87 ++++++++
 tb/tb_muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS definitions used by the multiply/divide unit.
package mips_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;
  localparam int MD_ITER = 32;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply/divide with architectural HI/LO registers.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} md_state_t;
  md_state_t   r_state;
  logic        r_div, r_neg, r_neg_rem, r_dz, r_done;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_mcand, r_hi, r_lo;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        w_signed, w_qok;
  logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_fix_hi, w_fix_lo;
  logic [32:0] w_sum, w_rsh;
  logic [33:0] w_diff;
  logic [63:0] w_prod;
  assign w_signed = (op == MD_MULT) || (op == MD_DIV);
  assign w_abs_a  = (w_signed && a[31]) ? -a : a;
  assign w_abs_b  = (w_signed && b[31]) ? -b : b;
  // Multiply: low half of acc is the multiplier, product shifts in from the top.
  assign w_sum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  // Divide: low half of acc shifts dividend bits out and quotient bits in.
  assign w_rsh    = {r_rem[31:0], r_acc[31]};
  assign w_diff   = {1'b0, w_rsh} - {2'b0, r_mcand};
  assign w_qok    = ~w_diff[33];
  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_q      = r_neg ? -r_acc[31:0] : r_acc[31:0];
  assign w_r      = r_neg_rem ? -r_rem[31:0] : r_rem[31:0];
  assign w_fix_hi = r_div ? (r_dz ? r_a : w_r) : w_prod[63:32];
  assign w_fix_lo = r_div ? (r_dz ? 32'hFFFF_FFFF : w_q) : w_prod[31:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && mthi) r_hi <= a;
      if (r_state == IDLE && mtlo) r_lo <= a;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE && start) begin
        r_div     <= op[1];
        r_neg     <= w_signed && (a[31] ^ b[31]);
        r_neg_rem <= w_signed && a[31];
        r_dz      <= (b == 32'd0);
        r_a       <= a;
        r_mcand   <= w_abs_b;
        r_acc     <= {32'd0, w_abs_a};
        r_rem     <= '0;
        r_cnt     <= '0;
        r_state   <= RUN;
      end else if (r_state == RUN) begin
        r_acc   <= r_div ? {r_acc[63:32], r_acc[30:0], w_qok} : {w_sum, r_acc[31:1]};
        r_rem   <= w_qok ? w_diff[32:0] : w_rsh;
        r_cnt   <= r_cnt + 5'd1;
        r_state <= (r_cnt == 5'(MD_ITER - 1)) ? FIX : RUN;
      end else if (r_state == FIX) begin
        r_hi    <= w_fix_hi;
        r_lo    <= w_fix_lo;
        r_done  <= 1'b1;
        r_state <= IDLE;
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, hand-written corner sequences and random ops against an arithmetic model.
module tb_muldiv_unit;
  import mips_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
  muldiv_op_t  op = MD_MULT;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;
  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    longint q, r;
    if (o == MD_MULT) return 64'(sx * sy);
    if (o == MD_MULTU) return 64'(ux * uy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = (o == MD_DIV) ? sx / sy : ux / uy;
    r = (o == MD_DIV) ? sx % sy : ux % uy;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic launch(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_op(input string name, input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp);
    int lat;
    launch(o, x, y);
    wait_done(lat);
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_hilo"}, {hi, lo}, exp);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask
  vec_t vecs[8];
  initial begin
    int lat, pulses;
    logic [31:0] x, y;
    muldiv_op_t o;
    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{MD_DIVU,  32'd7,        32'd2,         32'd1,         32'd3};
    vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vecs[6] = '{MD_DIVU,  32'd5,        32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[7] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    rst_n = 1'b1;
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
    // Preload, then a start+mthi mid-run and a flush must leave HI/LO untouched.
    @(negedge clk); a = 32'h1111_1111; mthi = 1'b1;
    @(negedge clk); a = 32'h2222_2222; mthi = 1'b0; mtlo = 1'b1;
    @(negedge clk); mtlo = 1'b0;
    chk("preload", {hi, lo}, 64'h1111_1111_2222_2222);
    launch(MD_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = MD_MULTU; a = 32'hDEAD_BEEF;
    @(negedge clk); start = 1'b0; mthi = 1'b0;
    chk("ignored_in_run", {31'd0, busy, hi}, {31'd1, 32'h1111_1111});
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(done);
    end
    chk("flush_no_done", 64'(pulses), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h1111_1111_2222_2222);
    // Flush landing on the FIX edge suppresses the write.
    launch(MD_MULTU, 32'd9, 32'd9);
    repeat (32) @(negedge clk);
    chk("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("fix_flush", {31'd0, busy, done, hi}, {31'd0, 2'b00, 32'h1111_1111});
    chk("fix_flush_lo", 64'(lo), 64'h2222_2222);
    // start together with mtlo: move visible first, result overwrites later.
    @(negedge clk); op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1; mtlo = 1'b1;
    @(negedge clk); start = 1'b0; mtlo = 1'b0;
    chk("start_mtlo_move", {31'd0, busy, lo}, {31'd1, 32'd3});
    wait_done(lat);
    chk("start_mtlo_result", {hi, lo}, 64'd15);
    // Reset mid-MULT, then a fresh MULT completes normally.
    launch(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_reset", {30'd0, busy, done, hi, lo}, 64'd0);
    run_op("after_reset", MD_MULT, 32'd6, 32'd7, 64'd42);
    for (int i = 0; i < 40; i++) begin
      o = muldiv_op_t'($urandom_range(3));
      x = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
      y = ($urandom_range(4) == 0) ? 32'($urandom_range(3)) : $urandom;
      if ($urandom_range(7) == 0) y = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", i), o, x, y, model(o, x, y));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
